vjtag_scan_master: RTL and testbench

- Host-side driver of the 2-bit-IR virtual JTAG protocol used by the Nios II debug slave.
- Converts one system-clock command (IR value plus 38-bit DR word) into a complete scan sequence: UIR, CDR, SDR shift and UDR.
- Generates tck/tdi and the virtual state strobes, and returns the captured tdo word and ir_out.
- Sits in simulation benches and on-chip self-test paths, directly in place of the sld_virtual_jtag_basic phy.

---
 rtl/vjtag_scan_master.sv | 169 ++++++++++++++++
 tb/tb_vjtag_scan_master.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vjtag_scan_master.sv
// Host-side virtual JTAG scan master: turns one command (IR + DR word) into a
// full UIR / CDR / SDR / UDR sequence on a generated tck and returns the captured DR.
module vjtag_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    input  logic [IR_WIDTH-1:0] ir_out,
    output logic                jtag_state_rti,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr
);

    localparam int DIV_W = (2 * TCK_DIV > 2) ? $clog2(2 * TCK_DIV) : 1;
    localparam int BIT_W = (DR_WIDTH > 2) ? $clog2(DR_WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * TCK_DIV - 1);
    // Divider value in the last low-tck cycle; the edge leaving it raises tck.
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(TCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DR_WIDTH-1:0] shift_q, shift_d;
    logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
    logic [IR_WIDTH-1:0] ir_shadow_q, ir_shadow_d;
    logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;
    logic                tck_q, tck_d;
    logic                tdi_q, tdi_d;

    logic active, period_end, tck_rise, accept, next_active;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        ir_in_d     = ir_in_q;
        ir_shadow_d = ir_shadow_q;
        rsp_data_d  = rsp_data_q;
        rsp_ir_d    = rsp_ir_q;
        tdi_d       = tdi_q;

        active     = (state_q == S_UIR) || (state_q == S_CDR) ||
                     (state_q == S_SDR) || (state_q == S_UDR);
        period_end = active && (div_q == DIV_LAST);
        tck_rise   = active && (div_q == DIV_RISE);
        accept     = cmd_valid && (state_q == S_IDLE);
        div_d      = (active && !period_end) ? div_q + 1'b1 : '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_UIR;
                    shift_d = cmd_data;
                    ir_in_d = cmd_ir;
                end
            end
            S_UIR: begin
                if (tck_rise)   ir_shadow_d = ir_out;
                if (period_end) state_d = S_CDR;
            end
            S_CDR: begin
                if (period_end) begin
                    state_d = S_SDR;
                    bit_d   = '0;
                end
            end
            S_SDR: begin
                // tdo enters at the MSB so the first captured bit ends at bit 0.
                if (tck_rise) shift_d = {tdo, shift_q[DR_WIDTH-1:1]};
                if (period_end) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = S_UDR;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_UDR: begin
                if (period_end) begin
                    state_d    = S_DONE;
                    rsp_data_d = shift_q;
                    rsp_ir_d   = ir_shadow_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        next_active = (state_d == S_UIR) || (state_d == S_CDR) ||
                      (state_d == S_SDR) || (state_d == S_UDR);
        tck_d       = next_active && (div_d > DIV_RISE);

        // tdi only moves on a period boundary, never at the mid-period shift.
        if (accept || period_end) begin
            tdi_d = ((state_d == S_CDR) || (state_d == S_SDR)) ? shift_d[0] : 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            ir_in_q     <= '0;
            ir_shadow_q <= '0;
            rsp_data_q  <= '0;
            rsp_ir_q    <= '0;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            ir_in_q     <= ir_in_d;
            ir_shadow_q <= ir_shadow_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ir_q    <= rsp_ir_d;
            tck_q       <= tck_d;
            tdi_q       <= tdi_d;
        end
    end

    assign cmd_ready      = (state_q == S_IDLE);
    assign jtag_state_rti = (state_q == S_IDLE);
    assign rsp_valid      = (state_q == S_DONE);
    assign vs_uir         = (state_q == S_UIR);
    assign vs_cdr         = (state_q == S_CDR);
    assign vs_sdr         = (state_q == S_SDR);
    assign vs_udr         = (state_q == S_UDR);
    assign rsp_data       = rsp_data_q;
    assign rsp_ir         = rsp_ir_q;
    assign ir_in          = ir_in_q;
    assign tck            = tck_q;
    assign tdi            = tdi_q;

endmodule

// File: tb/tb_vjtag_scan_master.sv
// Scoreboard bench for vjtag_scan_master: default build with a one-period-delay
// loopback slave model, plus a small DR_WIDTH=8 / TCK_DIV=1 build with direct loopback.
module tb_vjtag_scan_master;

    localparam int DRW  = 38;
    localparam int IRW  = 2;
    localparam int DIV  = 2;
    localparam int LAT  = 1 + (DRW + 3) * 2 * DIV;
    localparam int DRW2 = 8;
    localparam int DIV2 = 1;
    localparam int LAT2 = 1 + (DRW2 + 3) * 2 * DIV2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance signals
    logic           cmd_valid = 1'b0, cmd_ready;
    logic [IRW-1:0] cmd_ir = '0;
    logic [DRW-1:0] cmd_data = '0;
    logic           rsp_valid;
    logic [DRW-1:0] rsp_data;
    logic [IRW-1:0] rsp_ir, ir_in;
    logic [IRW-1:0] ir_out = '0;
    logic           tck, tdi, tdo, rti, vs_uir, vs_cdr, vs_sdr, vs_udr;

    // Small instance signals
    logic            cmd_valid_2 = 1'b0, cmd_ready_2;
    logic [IRW-1:0]  cmd_ir_2 = '0;
    logic [DRW2-1:0] cmd_data_2 = '0;
    logic            rsp_valid_2;
    logic [DRW2-1:0] rsp_data_2;
    logic [IRW-1:0]  rsp_ir_2, ir_in_2;
    logic            tck_2, tdi_2, tdo_2, rti_2, vs_uir_2, vs_cdr_2, vs_sdr_2, vs_udr_2;

    vjtag_scan_master #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_ir(rsp_ir), .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
        .jtag_state_rti(rti), .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr)
    );

    vjtag_scan_master #(.DR_WIDTH(DRW2), .IR_WIDTH(IRW), .TCK_DIV(DIV2)) dut_2 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid_2), .cmd_ready(cmd_ready_2),
        .cmd_ir(cmd_ir_2), .cmd_data(cmd_data_2), .rsp_valid(rsp_valid_2), .rsp_data(rsp_data_2),
        .rsp_ir(rsp_ir_2), .tck(tck_2), .tdi(tdi_2), .tdo(tdo_2), .ir_in(ir_in_2), .ir_out(2'b00),
        .jtag_state_rti(rti_2), .vs_uir(vs_uir_2), .vs_cdr(vs_cdr_2), .vs_sdr(vs_sdr_2), .vs_udr(vs_udr_2)
    );

    // Slave model: tdo presents the tdi bit shifted in at the previous SDR rising tck.
    bit   const_mode = 1'b0;
    logic lb_q = 1'b0;
    always @(posedge tck) begin
        if (vs_uir)      lb_q <= 1'b0;
        else if (vs_sdr) lb_q <= tdi;
    end
    assign tdo   = const_mode ? 1'b1 : lb_q;
    assign tdo_2 = tdi_2;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    typedef struct {
        logic [DRW-1:0] data;
        logic [IRW-1:0] ir_rsp;
        logic [IRW-1:0] ir_cmd;
        logic [DRW-1:0] tdi_seq;
        int             cyc;
        bit             const_mode;
    } exp_t;

    exp_t sb[$];
    logic [DRW2-1:0] sb2_data[$];
    int              sb2_cyc[$];

    // Per-scan monitor state for the main instance
    exp_t           e;
    logic           tck_prev = 1'b0;
    int             sdr_cnt = 0, excl_err = 0, order_err = 0, last_phase = 0, phase, nstrb;
    logic [3:0]     seen = '0;
    logic [DRW-1:0] tdi_seq = '0;
    bit             tdi_any = 1'b0, rsp_chg = 1'b0, reset_prev = 1'b1, b2b_expect = 1'b0;
    logic [DRW-1:0] rsp_prev = '0;
    int             last_rsp_cyc = -10, n_rsp = 0;

    always @(negedge clk) begin
        if (!reset) begin
            nstrb = int'(vs_uir) + int'(vs_cdr) + int'(vs_sdr) + int'(vs_udr);
            if (cmd_valid && cmd_ready) begin
                e.data       = const_mode ? '1 : (cmd_data << 1);
                e.ir_rsp     = ir_out;
                e.ir_cmd     = cmd_ir;
                e.tdi_seq    = cmd_data;
                e.cyc        = cyc + LAT;
                e.const_mode = const_mode;
                sb.push_back(e);
                if (b2b_expect) begin
                    check("b2b_accept_cycle", cyc, last_rsp_cyc + 1);
                    b2b_expect = 1'b0;
                end
                sdr_cnt = 0; excl_err = 0; order_err = 0; last_phase = 0;
                seen = '0; tdi_seq = '0; tdi_any = 1'b0;
            end
            if (rti || rsp_valid) begin
                if (nstrb != 0) excl_err++;
            end else if (nstrb != 1) begin
                excl_err++;
            end
            phase = vs_uir ? 1 : vs_cdr ? 2 : vs_sdr ? 3 : vs_udr ? 4 : 0;
            if (phase != 0) begin
                if (phase < last_phase) order_err++;
                last_phase = phase;
                seen[phase-1] = 1'b1;
            end
            if (tck && !tck_prev && vs_sdr) begin
                if (sdr_cnt < DRW) tdi_seq[sdr_cnt] = tdi;
                sdr_cnt++;
            end
            if (!rti && tdi) tdi_any = 1'b1;
            if (!rsp_valid && !reset_prev && rsp_data !== rsp_prev) rsp_chg = 1'b1;
            if (rsp_valid) begin
                n_rsp++;
                last_rsp_cyc = cyc;
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_ir", rsp_ir, e.ir_rsp);
                    check("ir_in_held", ir_in, e.ir_cmd);
                    check("rsp_latency", cyc, e.cyc);
                    check("sdr_tck_edges", sdr_cnt, DRW);
                    check("tdi_sequence", tdi_seq, e.tdi_seq);
                    check("strobes_seen", seen, 4'hF);
                    check("strobe_order", order_err, 0);
                    check("strobe_exclusive", excl_err, 0);
                    check("rsp_hold", rsp_chg, 0);
                    if (e.const_mode) check("tdi_zero", tdi_any, 0);
                end
                rsp_chg = 1'b0;
            end
        end
        tck_prev   = tck;
        rsp_prev   = rsp_data;
        reset_prev = reset;
    end

    // Monitor for the small instance
    logic tck2_prev = 1'b0;
    int   rise_2 = 0, high_2 = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (cmd_valid_2 && cmd_ready_2) begin
                sb2_data.push_back(cmd_data_2);
                sb2_cyc.push_back(cyc + LAT2);
                rise_2 = 0; high_2 = 0;
            end else if (!rti_2 && !rsp_valid_2) begin
                if (tck_2) high_2++;
                if (tck_2 && !tck2_prev) rise_2++;
            end
            if (rsp_valid_2) begin
                if (sb2_data.size() == 0) begin
                    check("rsp2_unexpected", 1, 0);
                end else begin
                    check("rsp2_data", rsp_data_2, sb2_data.pop_front());
                    check("rsp2_latency", cyc, sb2_cyc.pop_front());
                    check("tck2_rises", rise_2, DRW2 + 3);
                    check("tck2_high_cycles", high_2, (DRW2 + 3) * DIV2);
                end
            end
        end
        tck2_prev = tck_2;
    end

    task automatic send(input logic [DRW-1:0] d, input logic [IRW-1:0] ir, input bit keep);
        int n;
        n = 0;
        cmd_data  = d;
        cmd_ir    = ir;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("scan_done", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n, snap;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_rti", rti, 1'b1);
        check("rst_tck_tdi", {tck, tdi}, 2'b00);
        check("rst_strobes", {vs_uir, vs_cdr, vs_sdr, vs_udr}, 4'b0000);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_ir", rsp_ir, 0);
        check("rst_ir_in", ir_in, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single scan, delayed loopback
        const_mode = 1'b0; ir_out = 2'b11;
        send(38'h15_5555_5555, 2'b10, 1'b0);
        wait_done();

        // Constant capture
        const_mode = 1'b1; ir_out = 2'b01;
        send('0, 2'b01, 1'b0);
        wait_done();

        // Back-to-back with cmd_valid held
        const_mode = 1'b0; ir_out = 2'b10;
        send(38'h01_2345_6789, 2'b11, 1'b1);
        b2b_expect = 1'b1;
        send(38'h2A_0F0F_1234, 2'b00, 1'b0);
        wait_done();

        // Reset after 10 shifted bits
        send(38'h3C_3C3C_3C3C, 2'b01, 1'b0);
        n = 0;
        while (sdr_cnt < 10 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("sdr_10_reached", sdr_cnt, 10);
        snap  = n_rsp;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        check("abort_idle", {rti, cmd_ready}, 2'b11);
        check("abort_tck", tck, 1'b0);
        check("abort_strobes", {vs_uir, vs_cdr, vs_sdr, vs_udr}, 4'b0000);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        repeat (LAT + 10) @(posedge clk);
        #1;
        check("abort_no_rsp", n_rsp, snap);
        send(38'h0F_EDCB_A987, 2'b10, 1'b0);
        wait_done();

        // Busy ignore: a second request during CDR must be dropped
        send(38'h11_2233_4455, 2'b01, 1'b0);
        n = 0;
        while (!vs_cdr && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("cdr_reached", vs_cdr, 1'b1);
        snap      = n_rsp;
        cmd_data  = 38'h3A_BCDE_F012;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done();
        repeat (LAT + 10) @(posedge clk);
        #1;
        check("busy_one_rsp", n_rsp, snap + 1);

        // Small build: same-period loopback
        cmd_ir_2    = 2'b01;
        cmd_data_2  = 8'hA5;
        cmd_valid_2 = 1'b1;
        @(posedge clk); #1;
        cmd_valid_2 = 1'b0;
        n = 0;
        while (sb2_data.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("scan2_done", sb2_data.size(), 0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
